// File: rtl/led_blink_bank.sv
// led_blink_bank: a bank of NB_CH independent LED drivers that share one
// prescaler tick. Each channel can be set to OFF, ON, BLINK (programmable
// half-period in ticks) or ONESHOT (lit for a programmable number of ticks,
// then it drops back to OFF on its own).
//
// Optional build macro: LED_BANK_READBACK_EN adds a registered readback port
// for the mode and half-period of one selected channel.
//
// Ports (top):
//   sys_clk   in   system clock
//   sys_rst   in   synchronous active-high reset
//   cfg_we    in   single-cycle configuration write strobe
//   cfg_ch    in   target channel; values >= NB_CH are ignored
//   cfg_mode  in   0=OFF 1=ON 2=BLINK 3=ONESHOT
//   cfg_half  in   half-period in ticks (0 behaves as 1)
//   sync      in   realign the prescaler and every channel's phase
//   rd_ch     in   readback channel select        (LED_BANK_READBACK_EN only)
//   rd_mode   out  mode of rd_ch, one-cycle latency (LED_BANK_READBACK_EN only)
//   rd_half   out  half of rd_ch, one-cycle latency (LED_BANK_READBACK_EN only)
//   tick      out  one-cycle prescaler pulse
//   led       out  registered LED drive, 1 = lit

// ---------------------------------------------------------------------------
// led_blink_ch: one LED channel. Holds mode, half-period, tick counter and
// the registered LED bit.
// Ports: sys_clk, sys_rst, tick (shared prescaler pulse), sync (bank-wide
// phase realign), wr (write strobe already decoded for this channel),
// wr_mode, wr_half, mode_q/half_q (readback builds only), led.
// ---------------------------------------------------------------------------
module led_blink_ch #(
    parameter int HALF_W       = 8,
    parameter int DEFAULT_HALF = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              tick,
    input  logic              sync,
    input  logic              wr,
    input  logic [1:0]        wr_mode,
    input  logic [HALF_W-1:0] wr_half,
`ifdef LED_BANK_READBACK_EN
    output logic [1:0]        mode_q,
    output logic [HALF_W-1:0] half_q,
`endif
    output logic              led
);
    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

`ifdef LED_BANK_READBACK_EN
`else
    logic [1:0]        mode_q;
    logic [HALF_W-1:0] half_q;
`endif

    logic [HALF_W-1:0] h_cnt;
    logic [HALF_W-1:0] h_last;
    logic              counting;

    // Terminal count is eff_half-1; a half of 0 behaves as 1, so both
    // 0 and 1 give a terminal count of 0 and the subtraction never wraps.
    assign h_last   = (half_q == '0) ? '0 : half_q - 1'b1;
    assign counting = (mode_q == MODE_BLINK) || (mode_q == MODE_ONESHOT);

    // Priority: reset > write > sync > tick. A write in a tick cycle
    // drops that tick for this channel; a write in a sync cycle keeps the
    // freshly written state rather than the sync restart.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q <= MODE_OFF;
            half_q <= HALF_W'(DEFAULT_HALF);
            h_cnt  <= '0;
            led    <= 1'b0;
        end else if (wr) begin
            mode_q <= wr_mode;
            half_q <= wr_half;
            h_cnt  <= '0;
            led    <= (wr_mode != MODE_OFF);
        end else if (sync) begin
            h_cnt <= '0;
            if (counting) begin
                led <= 1'b1;
            end
        end else if (tick && counting) begin
            if (h_cnt == h_last) begin
                h_cnt <= '0;
                if (mode_q == MODE_ONESHOT) begin
                    led    <= 1'b0;
                    mode_q <= MODE_OFF;
                end else begin
                    led <= ~led;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end
endmodule

// ---------------------------------------------------------------------------
// led_blink_bank: shared prescaler, write decode, channel array, optional
// readback mux.
// ---------------------------------------------------------------------------
module led_blink_bank #(
    parameter  int NB_CH        = 4,
    parameter  int PRESCALE     = 50000000,
    parameter  int HALF_W       = 8,
    parameter  int DEFAULT_HALF = 1,
    localparam int CH_W         = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic              sync,
`ifdef LED_BANK_READBACK_EN
    input  logic [CH_W-1:0]   rd_ch,
    output logic [1:0]        rd_mode,
    output logic [HALF_W-1:0] rd_half,
`endif
    output logic              tick,
    output logic [NB_CH-1:0]  led
);
    localparam int PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0] pre_cnt;
    logic             pre_wrap;

    assign pre_wrap = (pre_cnt == PRE_W'(PRESCALE - 1));

    // tick is the terminal prescaler count, suppressed in a sync cycle so
    // that no channel advances while the bank is being realigned.
    assign tick = pre_wrap & ~sync & ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_cnt <= '0;
        end else if (sync || pre_wrap) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

`ifdef LED_BANK_READBACK_EN
    logic [NB_CH-1:0][1:0]        ch_mode;
    logic [NB_CH-1:0][HALF_W-1:0] ch_half;
`endif

    // Out-of-range cfg_ch matches no instance, so such a write is a no-op.
    for (genvar i = 0; i < NB_CH; i++) begin : g_ch
        led_blink_ch #(
            .HALF_W       (HALF_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .tick    (tick),
            .sync    (sync),
            .wr      (cfg_we && (cfg_ch == CH_W'(i))),
            .wr_mode (cfg_mode),
            .wr_half (cfg_half),
`ifdef LED_BANK_READBACK_EN
            .mode_q  (ch_mode[i]),
            .half_q  (ch_half[i]),
`endif
            .led     (led[i])
        );
    end

`ifdef LED_BANK_READBACK_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_mode <= '0;
            rd_half <= '0;
        end else if (int'(rd_ch) < NB_CH) begin
            rd_mode <= ch_mode[rd_ch];
            rd_half <= ch_half[rd_ch];
        end else begin
            rd_mode <= '0;
            rd_half <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_led_blink_bank.sv
// Bench for led_blink_bank. NB_CH=5 is used so that a 3-bit cfg_ch can
// address out-of-range channels (5..7). The reference model describes each
// channel by "ticks seen since last write/sync" and derives the LED from
// that with division; the prescaler phase is "cycles since last alignment".
module tb_led_blink_bank;
    localparam int NB = 5;
    localparam int P  = 4;
    localparam int HW = 8;
    localparam int CW = 3;

    logic          sys_clk  = 1'b0;
    logic          sys_rst  = 1'b1;
    logic          cfg_we   = 1'b0;
    logic [CW-1:0] cfg_ch   = '0;
    logic [1:0]    cfg_mode = '0;
    logic [HW-1:0] cfg_half = '0;
    logic          sync     = 1'b0;
    logic          tick;
    logic [NB-1:0] led;
`ifdef LED_BANK_READBACK_EN
    logic [CW-1:0] rd_ch = '0;
    logic [1:0]    rd_mode;
    logic [HW-1:0] rd_half;
`endif

    always #5 sys_clk = ~sys_clk;

    led_blink_bank #(
        .NB_CH        (NB),
        .PRESCALE     (P),
        .HALF_W       (HW),
        .DEFAULT_HALF (1)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .cfg_half (cfg_half),
        .sync     (sync),
`ifdef LED_BANK_READBACK_EN
        .rd_ch    (rd_ch),
        .rd_mode  (rd_mode),
        .rd_half  (rd_half),
`endif
        .tick     (tick),
        .led      (led)
    );

    typedef struct {
        int            cyc;
        logic          tick;
        logic [NB-1:0] led;
        logic [1:0]    rd_mode;
        logic [HW-1:0] rd_half;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_mode[NB];
    int m_half[NB];
    int m_n[NB];
    int since = 0;
    int cyc   = 0;
    int rd_nm = 0;
    int rd_nh = 0;

    function automatic int eff(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic logic exp_led(input int ch);
        logic v;
        case (m_mode[ch])
            0:       v = 1'b0;
            1:       v = 1'b1;
            2:       v = (((m_n[ch] / eff(m_half[ch])) % 2) == 0);
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    task automatic step(input bit we, input int ch, input int mode, input int half,
                        input bit s, input bit r, input int rch);
        exp_t e;
        bit   tk;
        @(posedge sys_clk);
        #1;
        sys_rst  = r;
        cfg_we   = we;
        cfg_ch   = CW'(ch);
        cfg_mode = 2'(mode);
        cfg_half = HW'(half);
        sync     = s;
`ifdef LED_BANK_READBACK_EN
        rd_ch    = CW'(rch);
`endif
        tk = ((since % P) == P - 1) && !s;
        if (!r) begin
            e.cyc     = cyc;
            e.tick    = tk;
            for (int k = 0; k < NB; k++) e.led[k] = exp_led(k);
            e.rd_mode = 2'(rd_nm);
            e.rd_half = HW'(rd_nh);
            sb_q.push_back(e);
        end
        if (r) begin
            for (int k = 0; k < NB; k++) begin
                m_mode[k] = 0;
                m_half[k] = 1;
                m_n[k]    = 0;
            end
            since = 0;
            cyc   = 0;
            rd_nm = 0;
            rd_nh = 0;
        end else begin
            if (rch < NB) begin
                rd_nm = m_mode[rch];
                rd_nh = m_half[rch];
            end else begin
                rd_nm = 0;
                rd_nh = 0;
            end
            for (int k = 0; k < NB; k++) begin
                if (we && ch == k) begin
                    m_mode[k] = mode;
                    m_half[k] = half;
                    m_n[k]    = 0;
                end else if (s) begin
                    m_n[k] = 0;
                end else if (tk && m_mode[k] >= 2) begin
                    m_n[k]++;
                    if (m_mode[k] == 3 && m_n[k] == eff(m_half[k])) m_mode[k] = 0;
                end
            end
            since = s ? 0 : since + 1;
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, int'($urandom_range(0, 7)));
    endtask

    task automatic check(input string name, input int c, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
        end
    endtask

    // Monitor: the DUT presents tick/led every cycle; compare at negedge.
    always @(negedge sys_clk) begin : mon
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("tick", e.cyc, 32'(tick), 32'(e.tick));
            check("led", e.cyc, 32'(led), 32'(e.led));
`ifdef LED_BANK_READBACK_EN
            check("rd_mode", e.cyc, 32'(rd_mode), 32'(e.rd_mode));
            check("rd_half", e.cyc, 32'(rd_half), 32'(e.rd_half));
`endif
        end
    end

    initial begin
        // 1: reset release, no writes, tick at 3, 7, 11
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);
        idle(13);

        // 2: BLINK half=2 written at cycle 0
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 2, 2, 0, 0, 0);
        idle(34);

        // 3: ONESHOT half=3 on ch1, readback pointed at ch1
        step(1, 1, 3, 3, 0, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 1);

        // 4: BLINK half=0 on ch2, then an out-of-range write
        step(1, 2, 2, 0, 0, 0, 2);
        idle(10);
        step(1, 5, 1, 7, 0, 0, 5);
        idle(10);

        // 5: ch3 BLINK at another phase, then sync with a coincident write on ch4
        step(1, 3, 2, 3, 0, 0, 3);
        idle(5);
        step(1, 4, 2, 1, 1, 0, 4);
        idle(30);

        // 6: write coincident with tick, then reset in the middle of a ONESHOT
        while ((since % P) != P - 1) idle(1);
        step(1, 0, 2, 1, 0, 0, 0);
        idle(9);
        step(1, 1, 3, 5, 0, 0, 1);
        idle(6);
        step(0, 0, 0, 0, 0, 1, 1);
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 4)),
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 199) == 0,
                 int'($urandom_range(0, 7)));
        end
        idle(2);
        @(negedge sys_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
